// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if
//  Requester-side bus of the shared-register arbiter.
//  master: client side (drives req/wdata[/lock], sees grant/owner/busy/q)
//  slave : arbiter side
//  req   NREQ        level-held request per requester
//  wdata NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  lock  1           only with REG_SHARE_LOCK_EN: owner may exceed HOLD
//  grant NREQ        one-hot ownership
//  owner OW          index of current/last owner
//  busy  1           high while granted and during the dead cycle after
//  q     WIDTH       shared register contents
interface reg_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
`ifdef REG_SHARE_LOCK_EN
  logic                  lock;
`endif
  logic [NREQ-1:0]       grant;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;

`ifdef REG_SHARE_LOCK_EN
  modport master (output req, wdata, lock, input grant, owner, busy, q);
  modport slave  (input req, wdata, lock, output grant, owner, busy, q);
`else
  modport master (output req, wdata, input grant, owner, busy, q);
  modport slave  (input req, wdata, output grant, owner, busy, q);
`endif
endinterface

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//  Round-robin arbiter/sequencer for one shared WIDTH-bit register.
//  NREQ requesters compete via req/grant; the owner's data is clocked
//  into q while it holds grant. All outputs are registered.
//  Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    reg_share_arbiter_if.slave (req, wdata, [lock], grant, owner, busy, q)
//  Build option: define REG_SHARE_LOCK_EN to add bus.lock, which lets the
//  owner keep the register past the HOLD limit while lock and its req are high.
module reg_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input logic                 clock,
  input logic                 reset,
  reg_share_arbiter_if.slave  bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [OW-1:0]    win;
  logic [OW-1:0]    owner_nxt;
  logic             cur_req, slot_end, stay;

  // First requester at or after p, circular. Scanning downward lets the
  // closest-to-p hit overwrite farther ones.
  function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] r,
                                         input logic [OW-1:0]   p);
    logic [OW-1:0] w;
    int            i;
    w = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      i = int'(p) + k;
      if (i >= NREQ) i = i - NREQ;
      if (r[i]) w = OW'(i);
    end
    return w;
  endfunction

  always_comb begin
    win       = pick(bus.req, ptr_q);
    owner_nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
    cur_req   = bus.req[owner_q];
    slot_end  = (cnt_q == CW'(HOLD - 1));
`ifdef REG_SHARE_LOCK_EN
    // lock overrides the slot limit; cnt stays parked at HOLD-1 meanwhile
    stay      = cur_req && (bus.lock || !slot_end);
`else
    stay      = cur_req && !slot_end;
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    q_d     = q_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          grant_d = NREQ'(1) << win;
          owner_d = win;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (stay) begin
          q_d = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
          if (!slot_end) cnt_d = cnt_q + CW'(1);
        end else begin
          // exit edge: no load, pointer moves past the departing owner
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = owner_nxt;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
module tb_reg_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic clock = 1'b0;
  logic reset;
  logic lk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  reg_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
`ifdef REG_SHARE_LOCK_EN
  assign bus.lock = lk;
`endif

  reg_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: ownership as "who holds it and for how many cycles",
  // plus a count of dead cycles left before arbitration resumes.
  int         m_owner;   // -1 when nobody owns
  int         m_held;    // cycles grant has been high in this ownership
  int         m_dead;    // dead cycles before next arbitration
  int         m_ptr;
  int         m_last;
  logic [7:0] m_q;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0; m_last = 0; m_q = 8'h00;
  endtask

  // Applies the rules for one rising edge using the inputs now on the bus.
  task automatic model_edge();
    if (m_owner >= 0) begin
      if (!bus.req[m_owner] || (!lk && m_held >= HOLD)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_dead  = 1;
      end else begin
        m_q    = bus.wdata[m_owner*WIDTH +: WIDTH];
        m_held = m_held + 1;
      end
    end else if (m_dead > 0) begin
      m_dead = m_dead - 1;
    end else if (|bus.req) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("owner", 32'(bus.owner), 32'(m_last));
    chk("busy",  32'(bus.busy),  32'((m_owner >= 0) || (m_dead > 0)));
    chk("q",     32'(bus.q),     32'(m_q));
  endtask

  task automatic cyc(input logic [3:0] r, input logic [31:0] wd);
    bus.req   = r;
    bus.wdata = wd;
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  logic [3:0]  rr;
  logic [31:0] wrd;

  initial begin
    reset = 1'b0;
    bus.req = '0;
    bus.wdata = '0;
    model_reset();
    #12;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_q",     32'(bus.q),     32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    @(negedge clock) reset = 1'b1;

    // single requester, HOLD limit reached while req still held
    cyc(4'b0100, 32'h00A5_0000);
    chk("a5_grant", 32'(bus.grant), 32'h4);
    chk("a5_owner", 32'(bus.owner), 32'h2);
    cyc(4'b0100, 32'h00A5_0000);
    chk("a5_q", 32'(bus.q), 32'hA5);
    cyc(4'b0100, 32'h00A5_0000);
    chk("a5_rel_grant", 32'(bus.grant), 32'h0);
    chk("a5_rel_busy",  32'(bus.busy),  32'h1);
    cyc(4'b0000, 32'h0);
    chk("a5_idle_busy", 32'(bus.busy), 32'h0);

    // ptr now 3: wrap-around 3 -> 0
    cyc(4'b1001, 32'h0);
    chk("wrap_first", 32'(bus.grant), 32'h8);
    for (int i = 0; i < 4; i++) cyc(4'b1001, 32'h0);
    chk("wrap_second", 32'(bus.grant), 32'h1);

    // all requesting: 0010,0100,1000,0001 with 2-cycle gaps
    for (int k = 0; k < 16; k++) begin
      cyc(4'b1111, 32'h4433_2211);
      if (k % 4 == 3) chk("rr_order", 32'(bus.grant), 32'd1 << ((1 + k / 4) % 4));
    end

    // owner 0 drops after one grant cycle: q keeps owner 3's last load
    cyc(4'b1110, 32'h4433_2211);
    chk("drop_grant", 32'(bus.grant), 32'h0);
    chk("drop_q",     32'(bus.q),     32'h44);
    cyc(4'b0000, 32'h0);
    cyc(4'b0011, 32'h0);
    chk("drop_ptr", 32'(bus.grant), 32'h2);

    // randomized traffic with level-held bias
    rr = 4'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      wrd = $urandom;
`ifdef REG_SHARE_LOCK_EN
      lk = ($urandom_range(0, 3) != 0);
`endif
      cyc(rr, wrd);
    end
    lk = 1'b0;

    // reset landing mid-grant
    for (int i = 0; i < 4; i++) cyc(4'b0000, 32'h0);
    cyc(4'b0100, 32'h0077_0000);
    chk("mid_pre_grant", 32'(bus.grant), 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("mid_grant", 32'(bus.grant), 32'h0);
    chk("mid_q",     32'(bus.q),     32'h0);
    chk("mid_busy",  32'(bus.busy),  32'h0);
    chk("mid_owner", 32'(bus.owner), 32'h0);
    model_reset();
    bus.req = '0;
    @(negedge clock) reset = 1'b1;

`ifdef REG_SHARE_LOCK_EN
    // lock keeps owner 0 beyond HOLD; once released, 0010 follows
    lk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0011, 32'h0000_2211);
      chk("lock_hold", 32'(bus.grant), 32'h1);
    end
    lk = 1'b0;
    for (int i = 0; i < 4; i++) cyc(4'b0011, 32'h0000_2211);
    chk("lock_next", 32'(bus.grant), 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
